// File: rtl/wb_sram_pkg.sv
// rtl/wb_sram_pkg.sv - shared types and helpers for the Wishbone SRAM controller
// Holds the FSM state enum and the bytewise merge used by read-modify-write.
package wb_sram_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } wb_sram_state_e;

  // Widest data path the merge helper supports; callers cast to/from DW.
  localparam int MAX_DW = 1024;

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0]   old_word,
    input logic [MAX_DW-1:0]   new_word,
    input logic [MAX_DW/8-1:0] sel
  );
    logic [MAX_DW-1:0] res;
    for (int b = 0; b < MAX_DW/8; b++) begin
      res[b*8 +: 8] = sel[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone B4 pipelined slave in front of a synchronous SRAM
// Zero-wait reads/writes; partial writes become a two-cycle read-modify-write when the SRAM lacks byte enables.
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4096,
  parameter int BYTE_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_cyc,
  input  logic                     wb_stb,
  input  logic                     wb_we,
  input  logic [AW-1:0]            wb_adr,
  input  logic [DW/8-1:0]          wb_sel,
  input  logic [DW-1:0]            wb_dat_i,
  output logic [DW-1:0]            wb_dat_o,
  output logic                     wb_ack,
  output logic                     wb_err,
  output logic                     wb_stall,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [DW/8-1:0]          mem_be,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int SW    = DW / 8;
  localparam int ADDRW = $clog2(DEPTH);
  localparam int IDXW  = AW - 2;
  localparam int CW    = (AW > 34) ? AW : 34;

  wb_sram_state_e state_q, state_d;

  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [SW-1:0]    sel_q, sel_d;

  logic [IDXW-1:0]  idx;
  logic             in_range;
  logic             accept;
  logic             unused_adr_lsb;

  assign idx            = wb_adr[AW-1:2];
  assign in_range       = (CW'(idx) < CW'(DEPTH));
  assign unused_adr_lsb = ^wb_adr[1:0];

  assign wb_stall = (state_q == ST_RMW);
  // Gating with rst_n keeps the SRAM quiet while reset is held, even mid-RMW.
  assign accept   = rst_n & wb_cyc & wb_stb & ~wb_stall;

  assign wb_ack   = ack_q & wb_cyc;
  assign wb_err   = err_q & wb_cyc;
  assign wb_dat_o = wb_ack ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else if (!wb_we) begin
            mem_en   = 1'b1;
            mem_addr = idx[ADDRW-1:0];
            ack_d    = 1'b1;
          end else if (wb_sel == '0) begin
            ack_d = 1'b1;
          end else if ((BYTE_EN != 0) || (wb_sel == '1)) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_be    = wb_sel;
            mem_addr  = idx[ADDRW-1:0];
            mem_wdata = wb_dat_i;
            ack_d     = 1'b1;
          end else begin
            // Partial write without byte enables: fetch the old word first.
            mem_en   = 1'b1;
            mem_addr = idx[ADDRW-1:0];
            addr_d   = idx[ADDRW-1:0];
            data_d   = wb_dat_i;
            sel_d    = wb_sel;
            state_d  = ST_RMW;
          end
        end
      end

      ST_RMW: begin
        state_d = ST_IDLE;
        if (rst_n && wb_cyc) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_be    = '1;
          mem_addr  = addr_q;
          mem_wdata = DW'(byte_merge(MAX_DW'(mem_rdata), MAX_DW'(data_q), (MAX_DW/8)'(sel_q)));
          ack_d     = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb/tb_wb_sram_ctrl.sv - directed self-checking bench for wb_sram_ctrl
// Two instances share the Wishbone stimulus: one with native byte enables, one using read-modify-write.
module tb_wb_sram_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int SW    = DW / 8;
  localparam int MA    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_i;

  logic [DW-1:0] d1_dat_o, d0_dat_o;
  logic          d1_ack, d1_err, d1_stall, d0_ack, d0_err, d0_stall;
  logic          d1_mem_en, d1_mem_we, d0_mem_en, d0_mem_we;
  logic [SW-1:0] d1_mem_be, d0_mem_be;
  logic [MA-1:0] d1_mem_addr, d0_mem_addr;
  logic [DW-1:0] d1_mem_wdata, d0_mem_wdata, d1_mem_rdata, d0_mem_rdata;

  logic          pl_en;
  logic [MA-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem0 [DEPTH];

  int checks = 0;
  int errors = 0;

  wb_sram_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .BYTE_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(d1_dat_o),
    .wb_ack(d1_ack), .wb_err(d1_err), .wb_stall(d1_stall),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_be(d1_mem_be),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
  );

  wb_sram_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .BYTE_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(d0_dat_o),
    .wb_ack(d0_ack), .wb_err(d0_err), .wb_stall(d0_stall),
    .mem_en(d0_mem_en), .mem_we(d0_mem_we), .mem_be(d0_mem_be),
    .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata), .mem_rdata(d0_mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
    end else if (d1_mem_en) begin
      if (d1_mem_we) begin
        for (int b = 0; b < SW; b++) begin
          if (d1_mem_be[b]) mem1[d1_mem_addr][b*8 +: 8] <= d1_mem_wdata[b*8 +: 8];
        end
      end
      d1_mem_rdata <= mem1[d1_mem_addr];
    end
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
    end else if (d0_mem_en) begin
      if (d0_mem_we) begin
        for (int b = 0; b < SW; b++) begin
          if (d0_mem_be[b]) mem0[d0_mem_addr][b*8 +: 8] <= d0_mem_wdata[b*8 +: 8];
        end
      end
      d0_mem_rdata <= mem0[d0_mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [MA-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic req(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                     input logic [DW-1:0] dat);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_sel   = sel;
    wb_dat_i = dat;
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_sel   = '0;
    wb_dat_i = '0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;

    #2;
    check_eq("rst_ack",    32'(d1_ack),       32'd0);
    check_eq("rst_err",    32'(d0_err),       32'd0);
    check_eq("rst_stall",  32'(d0_stall),     32'd0);
    check_eq("rst_dat_o",  d1_dat_o,          32'd0);

    // A request presented while reset is held must not reach the SRAM.
    req(1'b1, 32'd8, 4'hF, 32'hFFFF_FFFF);
    #1;
    check_eq("rst_mem_en",    32'(d1_mem_en),    32'd0);
    check_eq("rst_mem_wdata", d1_mem_wdata,      32'd0);
    check_eq("rst_mem_addr",  32'(d0_mem_addr),  32'd0);
    check_eq("rst_mem_be",    32'(d0_mem_be),    32'd0);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    preload(4'd5,  32'hDEAD_BEEF);
    preload(4'd7,  32'h1122_3344);
    preload(4'd9,  32'h5566_7788);
    preload(4'd10, 32'hCAFE_F00D);

    // Single read of word 5.
    req(1'b0, 32'd20, 4'hF, 32'd0);
    #1;
    check_eq("rd_mem_en",   32'(d1_mem_en),   32'd1);
    check_eq("rd_mem_we",   32'(d1_mem_we),   32'd0);
    check_eq("rd_mem_addr", 32'(d1_mem_addr), 32'd5);
    check_eq("rd_stall_t",  32'(d1_stall),    32'd0);
    check_eq("rd_ack_t",    32'(d1_ack),      32'd0);
    tick();
    wb_stb = 1'b0;
    #1;
    check_eq("rd_ack",      32'(d1_ack),   32'd1);
    check_eq("rd_dat",      d1_dat_o,      32'hDEAD_BEEF);
    check_eq("rd_err",      32'(d1_err),   32'd0);
    check_eq("rd_stall_t1", 32'(d1_stall), 32'd0);
    check_eq("rd0_dat",     d0_dat_o,      32'hDEAD_BEEF);
    tick();
    check_eq("rd_ack_pulse", 32'(d1_ack), 32'd0);

    // Four back-to-back full writes then four reads of words 0..3.
    for (int i = 0; i < 8; i++) begin
      req(i < 4, 32'((i % 4) * 4), 4'hF, 32'hA500_0000 | 32'(i));
      #1;
      check_eq("b2b_stall", 32'(d1_stall), 32'd0);
      if (i > 0) check_eq("b2b_ack", 32'(d1_ack), 32'd1);
      if (i >= 5) check_eq("b2b_dat", d1_dat_o, 32'hA500_0000 | 32'(i - 5));
      tick();
    end
    wb_stb = 1'b0;
    #1;
    check_eq("b2b_ack_last", 32'(d1_ack), 32'd1);
    check_eq("b2b_dat_last", d1_dat_o,    32'hA500_0003);
    tick();
    check_eq("b2b_idle", 32'(d1_ack), 32'd0);

    // Partial write of byte 1 into word 7.
    req(1'b1, 32'd28, 4'h2, 32'hAABB_CCDD);
    #1;
    check_eq("rmw_rd_en",   32'(d0_mem_en), 32'd1);
    check_eq("rmw_rd_we",   32'(d0_mem_we), 32'd0);
    check_eq("rmw_stall_t", 32'(d0_stall),  32'd0);
    check_eq("be1_be",      32'(d1_mem_be), 32'h2);
    tick();
    wb_stb = 1'b0;
    #1;
    check_eq("rmw_stall",  32'(d0_stall),     32'd1);
    check_eq("rmw_we",     32'(d0_mem_we),    32'd1);
    check_eq("rmw_be",     32'(d0_mem_be),    32'hF);
    check_eq("rmw_wdata",  d0_mem_wdata,      32'h1122_CC44);
    check_eq("rmw_ack_t1", 32'(d0_ack),       32'd0);
    check_eq("be1_ack",    32'(d1_ack),       32'd1);
    check_eq("be1_word",   mem1[7],           32'h1122_CC44);
    tick();
    check_eq("rmw_ack",    32'(d0_ack),   32'd1);
    check_eq("rmw_stall2", 32'(d0_stall), 32'd0);
    check_eq("rmw_word",   mem0[7],       32'h1122_CC44);
    tick();
    check_eq("rmw_ack_pulse", 32'(d0_ack), 32'd0);

    // Out-of-range index DEPTH.
    req(1'b0, 32'(DEPTH * 4), 4'hF, 32'd0);
    #1;
    check_eq("oor_mem_en", 32'(d1_mem_en), 32'd0);
    check_eq("oor_mem_en0", 32'(d0_mem_en), 32'd0);
    tick();
    wb_stb = 1'b0;
    #1;
    check_eq("oor_err", 32'(d1_err), 32'd1);
    check_eq("oor_ack", 32'(d1_ack), 32'd0);
    tick();
    check_eq("oor_err_pulse", 32'(d1_err), 32'd0);

    // Partial write abandoned by dropping wb_cyc during RMW.
    req(1'b1, 32'd36, 4'h1, 32'h0000_00FF);
    tick();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    #1;
    check_eq("drop_stall", 32'(d0_stall),  32'd1);
    check_eq("drop_en",    32'(d0_mem_en), 32'd0);
    check_eq("drop_ack1",  32'(d1_ack),    32'd0);
    tick();
    check_eq("drop_stall2", 32'(d0_stall), 32'd0);
    check_eq("drop_ack",    32'(d0_ack),   32'd0);
    check_eq("drop_word",   mem0[9],       32'h5566_7788);

    // Reset asserted while the RMW merge is pending.
    req(1'b1, 32'd40, 4'h4, 32'h0012_0000);
    tick();
    wb_stb = 1'b0;
    #1;
    check_eq("rrst_stall_pre", 32'(d0_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rrst_stall", 32'(d0_stall),  32'd0);
    check_eq("rrst_en",    32'(d0_mem_en), 32'd0);
    check_eq("rrst_we",    32'(d0_mem_we), 32'd0);
    check_eq("rrst_wdata", d0_mem_wdata,   32'd0);
    check_eq("rrst_ack",   32'(d0_ack),    32'd0);
    check_eq("rrst_ack1",  32'(d1_ack),    32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rrst_ack_after",  32'(d0_ack), 32'd0);
    tick();
    check_eq("rrst_ack_after2", 32'(d0_ack), 32'd0);
    check_eq("rrst_word",       mem0[10],    32'hCAFE_F00D);
    check_eq("rrst_word1",      mem1[10],    32'hCA12_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the Wishbone byte-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width (multiple of 8).
REQ-003 The block SHALL have parameter DEPTH, default 4096, meaning the number of SRAM words.
REQ-004 The block SHALL have parameter BYTE_EN, default 1, where 1 means the SRAM has native byte enables and 0 means partial writes use read-modify-write.
REQ-005 The block SHALL have ports clk  in  1  single clock; all logic on its rising edge.
REQ-006 The block SHALL have ports rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have ports wb_cyc, wb_stb, wb_we  in  1 each  Wishbone B4 pipelined slave cycle, strobe, write.
REQ-008 The block SHALL have ports wb_adr  in  AW  byte address, and wb_sel  in  DW/8  byte selects.
REQ-009 The block SHALL have ports wb_dat_i  in  DW  write data, and wb_dat_o  out  DW  read data.
REQ-010 The block SHALL have ports wb_ack, wb_err, wb_stall  out  1 each  Wishbone completion, error, and backpressure.
REQ-011 The block SHALL have ports mem_en, mem_we  out  1 each; mem_be  out  DW/8; mem_addr  out  clog2(DEPTH); mem_wdata  out  DW; mem_rdata  in  DW  (synchronous SRAM, read data valid one cycle after mem_en).

Function
REQ-012 A request SHALL be accepted in cycle T iff wb_cyc & wb_stb & ~wb_stall.
REQ-013 Word index is wb_adr[AW-1:2]; index >= DEPTH SHALL produce no mem access and wb_err=1 (wb_ack=0) at T+1.
REQ-014 A read accepted at T SHALL drive mem_en=1, mem_we=0 in T, and wb_ack=1 with wb_dat_o=mem_rdata at T+1.
REQ-015 A write with BYTE_EN=1, or with wb_sel all-ones, SHALL drive mem_en=mem_we=1, mem_be=wb_sel, mem_wdata=wb_dat_i in T, and wb_ack=1 at T+1.
REQ-016 A write with wb_sel=0 SHALL perform no mem access and return wb_ack=1 at T+1.
REQ-017 With BYTE_EN=0, a partial write SHALL use FSM IDLE->RMW: read issued at T with address, sel and data latched; in T+1, mem_rdata merged bytewise (sel=1 takes latched data), mem write all-ones mem_be, wb_ack=1 at T+2, back to IDLE.
REQ-018 wb_stall SHALL be 1 exactly while state=RMW; it SHALL be 0 in IDLE (zero-wait back-to-back throughput of one request per cycle).
REQ-019 wb_ack and wb_err SHALL be single-cycle pulses, never both high, and responses SHALL return in acceptance order.
REQ-020 If wb_cyc is low in a response cycle, wb_ack/wb_err SHALL be suppressed; if wb_cyc is low while in RMW, the merge write SHALL be dropped and FSM SHALL return to IDLE.
REQ-021 A request accepted in the cycle an earlier response is driven SHALL be handled normally (response and new acceptance coincide).
REQ-022 wb_dat_o SHALL be don't-care when wb_ack=0; mem_* outputs SHALL be 0 when mem_en=0.

Reset
REQ-023 On rst_n=0: FSM=IDLE, wb_ack=0, wb_err=0, wb_stall=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_dat_o=0, all pending-response state cleared.
REQ-024 Reset asserted mid-RMW SHALL drop the pending write; no ack SHALL follow deassertion.

Structure
REQ-025 A package wb_sram_pkg SHALL hold the FSM state enum (IDLE, RMW) and the byte-merge function.
REQ-026 No sub-module; SRAM macro is external.

Verification
REQ-027 Read idx 5 after reset, SRAM word 5=0xDEADBEEF -> ack at T+1, wb_dat_o=0xDEADBEEF, wb_stall=0 throughout.
REQ-028 Four back-to-back writes idx 0..3, sel=0xF, then four reads -> one ack per cycle, readback matches, no stall.
REQ-029 BYTE_EN=0, word=0x11223344, write sel=0x2 data=0xAABBCCDD -> stall=1 at T+1, ack at T+2, word=0x1122CC44.
REQ-030 Access idx DEPTH (adr=DEPTH*4) -> wb_err=1 at T+1, wb_ack=0, mem_en=0.
REQ-031 BYTE_EN=0 partial write, wb_cyc dropped at T+1 -> no write, no ack, stall=0 at T+2.
REQ-032 rst_n low during RMW -> all outputs 0 immediately, word unchanged, no ack after release.
